// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and default sizing for the data-buffer pool.
package vector_cache_pkg;

    localparam int DB_POOL_ENTRY_NUM  = 64;
    localparam int DB_POOL_DATA_WIDTH = 1024;
    localparam int DB_POOL_STRB_WIDTH = DB_POOL_DATA_WIDTH / 8;
    localparam int RW_DB_ENTRY_NUM    = 64;

    // One pool entry at default sizing: payload plus accumulated byte-valid mask.
    typedef struct packed {
        logic [DB_POOL_DATA_WIDTH-1:0] data;
        logic [DB_POOL_STRB_WIDTH-1:0] strb;
    } db_pool_entry_t;

endpackage

// File: rtl/vec_cache_ff1.sv
// Find-first-one: lowest set bit of vec_i and whether any bit is set.
module vec_cache_ff1 #(
    parameter  int N  = 64,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    // Scan high to low so the last hit kept is the lowest index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_cache_db_pool.sv
// Data-buffer pool: allocate lowest free entry, byte-merge, 1-cycle read,
// release, sticky protocol error. Optional occupancy statistics ports
// (occ_cnt/occ_max) are built when VEC_CACHE_DB_STAT_EN is defined.
module vec_cache_db_pool
    import vector_cache_pkg::*;
#(
    parameter  int ENTRY_NUM  = DB_POOL_ENTRY_NUM,
    parameter  int DATA_WIDTH = DB_POOL_DATA_WIDTH,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_WIDTH  = $clog2(ENTRY_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_vld,
    output logic                  alloc_rdy,
    input  logic [DATA_WIDTH-1:0] alloc_data,
    input  logic [STRB_WIDTH-1:0] alloc_strb,
    output logic [IDX_WIDTH-1:0]  alloc_id,
    input  logic                  mrg_vld,
    input  logic [IDX_WIDTH-1:0]  mrg_id,
    input  logic [DATA_WIDTH-1:0] mrg_data,
    input  logic [STRB_WIDTH-1:0] mrg_strb,
    input  logic                  rd_vld,
    input  logic [IDX_WIDTH-1:0]  rd_id,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [STRB_WIDTH-1:0] rd_strb,
    input  logic                  rel_vld,
    input  logic [IDX_WIDTH-1:0]  rel_id,
    output logic                  err
`ifdef VEC_CACHE_DB_STAT_EN
    ,
    output logic [IDX_WIDTH:0]    occ_cnt,
    output logic [IDX_WIDTH:0]    occ_max
`endif
);

    logic [ENTRY_NUM-1:0]  free_q, free_d;
    logic [DATA_WIDTH-1:0] data_q [ENTRY_NUM];
    logic [STRB_WIDTH-1:0] strb_q [ENTRY_NUM];
    logic                  rd_vld_q, err_q, stall_q;
    logic [DATA_WIDTH-1:0] rd_data_q, stall_data_q;
    logic [STRB_WIDTH-1:0] rd_strb_q;
    logic                  alloc_fire, rel_ok, mrg_ok, err_ev;

    vec_cache_ff1 #(.N(ENTRY_NUM)) u_ff1 (
        .vec_i   (free_q),
        .idx_o   (alloc_id),
        .found_o (alloc_rdy)
    );

    // Qualify each operation against pre-edge ownership; illegal ones only raise err.
    always_comb begin
        alloc_fire = alloc_vld && alloc_rdy;
        rel_ok     = rel_vld && !free_q[rel_id];
        mrg_ok     = mrg_vld && !free_q[mrg_id] && !(rel_vld && (rel_id == mrg_id));
        err_ev     = (rel_vld && free_q[rel_id])
                   || (mrg_vld && free_q[mrg_id])
                   || (mrg_vld && rel_vld && (mrg_id == rel_id))
                   || (rd_vld && free_q[rd_id])
                   || (stall_q && alloc_vld && (alloc_data != stall_data_q));
        free_d = free_q;
        // A released entry only becomes grantable next cycle: alloc_id comes from free_q.
        if (alloc_fire) free_d[alloc_id] = 1'b0;
        if (rel_ok)     free_d[rel_id]   = 1'b1;
    end

    // Control state and read response; reset clears ownership and discards reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_q    <= '1;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            rd_strb_q <= '0;
            err_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            free_q   <= free_d;
            rd_vld_q <= rd_vld;
            if (rd_vld) begin
                rd_data_q <= data_q[rd_id];
                rd_strb_q <= strb_q[rd_id];
            end
            err_q   <= err_q | err_ev;
            stall_q <= alloc_vld && !alloc_rdy;
        end
    end

    // Entry storage and the held-alloc payload are not reset.
    always_ff @(posedge clk) begin
        stall_data_q <= alloc_data;
        if (alloc_fire) begin
            data_q[alloc_id] <= alloc_data;
            strb_q[alloc_id] <= alloc_strb;
        end
        if (mrg_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (mrg_strb[b]) data_q[mrg_id][b*8 +: 8] <= mrg_data[b*8 +: 8];
            end
            strb_q[mrg_id] <= strb_q[mrg_id] | mrg_strb;
        end
    end

    assign rd_data_vld = rd_vld_q;
    assign rd_data     = rd_data_q;
    assign rd_strb     = rd_strb_q;
    assign err         = err_q;

`ifdef VEC_CACHE_DB_STAT_EN
    logic [IDX_WIDTH:0] occ_cnt_q, occ_cnt_d, occ_max_q, occ_max_d;

    // Occupancy tracks legal grants and releases; a simultaneous pair cancels.
    always_comb begin
        occ_cnt_d = occ_cnt_q;
        if (alloc_fire && !rel_ok)      occ_cnt_d = occ_cnt_q + (IDX_WIDTH+1)'(1);
        else if (!alloc_fire && rel_ok) occ_cnt_d = occ_cnt_q - (IDX_WIDTH+1)'(1);
        occ_max_d = (occ_cnt_d > occ_max_q) ? occ_cnt_d : occ_max_q;
    end

    // Occupancy and high-watermark registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_cnt_q <= '0;
            occ_max_q <= '0;
        end else begin
            occ_cnt_q <= occ_cnt_d;
            occ_max_q <= occ_max_d;
        end
    end

    assign occ_cnt = occ_cnt_q;
    assign occ_max = occ_max_q;
`endif

endmodule

// File: tb/tb_vec_cache_db_pool.sv
// Self-checking bench for vec_cache_db_pool against a behavioural pool model.
module tb_vec_cache_db_pool;

    localparam int N  = 64;
    localparam int DW = 1024;
    localparam int SW = DW / 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_vld, alloc_rdy;
    logic [DW-1:0] alloc_data;
    logic [SW-1:0] alloc_strb;
    logic [IW-1:0] alloc_id;
    logic          mrg_vld;
    logic [IW-1:0] mrg_id;
    logic [DW-1:0] mrg_data;
    logic [SW-1:0] mrg_strb;
    logic          rd_vld;
    logic [IW-1:0] rd_id;
    logic          rd_data_vld;
    logic [DW-1:0] rd_data;
    logic [SW-1:0] rd_strb;
    logic          rel_vld;
    logic [IW-1:0] rel_id;
    logic          err;
`ifdef VEC_CACHE_DB_STAT_EN
    logic [IW:0]   occ_cnt, occ_max;
`endif

    always #5 clk = ~clk;

    vec_cache_db_pool #(.ENTRY_NUM(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_data(alloc_data),
        .alloc_strb(alloc_strb), .alloc_id(alloc_id),
        .mrg_vld(mrg_vld), .mrg_id(mrg_id), .mrg_data(mrg_data), .mrg_strb(mrg_strb),
        .rd_vld(rd_vld), .rd_id(rd_id), .rd_data_vld(rd_data_vld),
        .rd_data(rd_data), .rd_strb(rd_strb),
        .rel_vld(rel_vld), .rel_id(rel_id), .err(err)
`ifdef VEC_CACHE_DB_STAT_EN
        , .occ_cnt(occ_cnt), .occ_max(occ_max)
`endif
    );

    // Reference model: ownership, contents, sticky error, occupancy.
    bit            own_m [N];
    logic [DW-1:0] data_m [N];
    logic [SW-1:0] strb_m [N];
    bit            err_m, stall_m;
    logic [DW-1:0] stall_dat_m;
    int            occ_m, occmax_m;
    bit            exp_vld, exp_known;
    logic [DW-1:0] exp_rd;
    logic [SW-1:0] exp_rs;
    int            n_chk, n_fail;
    int            q[$];
    logic [DW-1:0] old_dat;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [DW-1:0] rnd_dw();
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [SW-1:0] rnd_sw();
        logic [SW-1:0] v;
        for (int w = 0; w < SW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle();
        rst = 1'b0; alloc_vld = 1'b0; mrg_vld = 1'b0; rd_vld = 1'b0; rel_vld = 1'b0;
    endtask

    // One clock: check combinational grant, advance model, check registered outputs.
    task automatic cycle();
        int  lf;
        bit  rdy, rd_ok, a_fire, r_ok, m_ok, e;
        logic [DW-1:0] rdd;
        logic [SW-1:0] rds;
        #1;
        lf = -1;
        for (int i = N - 1; i >= 0; i--) if (!own_m[i]) lf = i;
        rdy = (lf >= 0);
        if (!rst) begin
            chk("alloc_rdy", alloc_rdy, rdy);
            if (rdy) chk("alloc_id", alloc_id, lf);
        end
        rd_ok  = rd_vld && own_m[rd_id];
        rdd    = data_m[rd_id];
        rds    = strb_m[rd_id];
        a_fire = alloc_vld && rdy;
        r_ok   = rel_vld && own_m[rel_id];
        m_ok   = mrg_vld && own_m[mrg_id] && !(rel_vld && rel_id == mrg_id);
        e = (rel_vld && !own_m[rel_id]) || (mrg_vld && !own_m[mrg_id])
          || (mrg_vld && rel_vld && mrg_id == rel_id) || (rd_vld && !own_m[rd_id])
          || (stall_m && alloc_vld && alloc_data !== stall_dat_m);
        if (rst) begin
            for (int i = 0; i < N; i++) own_m[i] = 1'b0;
            err_m = 1'b0; stall_m = 1'b0; occ_m = 0; occmax_m = 0;
            exp_vld = 1'b0; exp_known = 1'b1; exp_rd = '0; exp_rs = '0;
        end else begin
            if (a_fire) begin
                own_m[lf] = 1'b1; data_m[lf] = alloc_data; strb_m[lf] = alloc_strb;
            end
            if (m_ok) begin
                for (int b = 0; b < SW; b++)
                    if (mrg_strb[b]) data_m[mrg_id][b*8 +: 8] = mrg_data[b*8 +: 8];
                strb_m[mrg_id] = strb_m[mrg_id] | mrg_strb;
            end
            if (r_ok) own_m[rel_id] = 1'b0;
            err_m       = err_m | e;
            stall_m     = alloc_vld && !rdy;
            stall_dat_m = alloc_data;
            occ_m       = occ_m + int'(a_fire) - int'(r_ok);
            if (occ_m > occmax_m) occmax_m = occ_m;
            exp_vld = rd_vld;
            if (rd_vld) begin exp_known = rd_ok; exp_rd = rdd; exp_rs = rds; end
        end
        @(posedge clk); #1;
        chk("rd_data_vld", rd_data_vld, exp_vld);
        if (exp_vld && exp_known) begin
            chk("rd_data", rd_data, exp_rd);
            chk("rd_strb", rd_strb, exp_rs);
        end
        chk("err", err, err_m);
`ifdef VEC_CACHE_DB_STAT_EN
        chk("occ_cnt", occ_cnt, occ_m);
        chk("occ_max", occ_max, occmax_m);
`endif
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_strb", rd_strb, 0);
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            idle(); alloc_vld = 1'b1; alloc_data = rnd_dw(); alloc_strb = rnd_sw();
            cycle();
        end
        idle();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        alloc_data = '0; alloc_strb = '0; mrg_id = '0; mrg_data = '0; mrg_strb = '0;
        rd_id = '0; rel_id = '0;
        do_reset();
        chk("rst_alloc_rdy", alloc_rdy, 1);
        chk("rst_alloc_id", alloc_id, 0);

        // Fill the pool in order.
        for (int i = 0; i < N; i++) begin
            idle(); alloc_vld = 1'b1; alloc_data = rnd_dw(); alloc_strb = rnd_sw();
            chk("fill_id", alloc_id, i);
            cycle();
        end
        idle();
        chk("full_rdy", alloc_rdy, 0);
`ifdef VEC_CACHE_DB_STAT_EN
        chk("full_occ", occ_cnt, N);
`endif

        // Release while full: no same-cycle grant, grant next cycle.
        alloc_vld = 1'b1; alloc_data = rnd_dw(); alloc_strb = rnd_sw();
        rel_vld = 1'b1; rel_id = IW'(17);
        chk("full_nogrant", alloc_rdy, 0);
        cycle();
        rel_vld = 1'b0;
        chk("regrant_id", alloc_id, 17);
        cycle();
        idle();

        // Zero alloc, merge DEADBEEF into bytes 0-3, read back.
        rel_vld = 1'b1; rel_id = IW'(3); cycle(); idle();
        alloc_vld = 1'b1; alloc_data = '0; alloc_strb = '0; cycle(); idle();
        mrg_vld = 1'b1; mrg_id = IW'(3); mrg_data = DW'(32'hDEADBEEF); mrg_strb = SW'(4'hF);
        cycle(); idle();
        rd_vld = 1'b1; rd_id = IW'(3); cycle(); idle();
        chk("merge_lo", rd_data[31:0], 32'hDEADBEEF);
        chk("merge_strb", rd_strb, 4'hF);

        // Same-cycle read and merge to id 5 returns old data.
        old_dat = data_m[5];
        rd_vld = 1'b1; rd_id = IW'(5);
        mrg_vld = 1'b1; mrg_id = IW'(5); mrg_data = rnd_dw(); mrg_strb = rnd_sw() | SW'(1);
        cycle(); idle();
        chk("rdmrg_old", rd_data, old_dat);
        rd_vld = 1'b1; rd_id = IW'(5); cycle(); idle();

        // Random legal traffic.
        for (int c = 0; c < 1500; c++) begin
            q.delete();
            for (int i = 0; i < N; i++) if (own_m[i]) q.push_back(i);
            idle();
            if (q.size() < N && $urandom_range(0, 1) == 1) begin
                alloc_vld = 1'b1; alloc_data = rnd_dw(); alloc_strb = rnd_sw();
            end
            if (q.size() > 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    mrg_vld = 1'b1; mrg_id = IW'(q[$urandom_range(0, q.size() - 1)]);
                    mrg_data = rnd_dw(); mrg_strb = rnd_sw();
                end
                if ($urandom_range(0, 1) == 1) begin
                    rel_vld = 1'b1; rel_id = IW'(q[$urandom_range(0, q.size() - 1)]);
                    if (mrg_vld && rel_id == mrg_id) rel_vld = 1'b0;
                end
                if ($urandom_range(0, 1) == 1) begin
                    rd_vld = 1'b1; rd_id = IW'(q[$urandom_range(0, q.size() - 1)]);
                end
            end
            cycle();
        end
        idle();

        // Double release of id 9.
        do_reset();
        alloc_n(10);
        rel_vld = 1'b1; rel_id = IW'(9); cycle();
        chk("rel_once_err", err, 0);
        cycle(); idle();
        chk("dbl_rel_err", err, 1);
        alloc_vld = 1'b1; alloc_data = rnd_dw(); alloc_strb = rnd_sw();
        chk("dbl_rel_id", alloc_id, 9);
        cycle(); idle();
        for (int i = 0; i < 4; i++) cycle();
        chk("err_held", err, 1);

        // Other illegal operations, each from a clean pool.
        for (int k = 0; k < 3; k++) begin
            do_reset();
            alloc_n(2);
            case (k)
                0: begin mrg_vld = 1'b1; mrg_id = IW'(5); mrg_data = rnd_dw(); mrg_strb = rnd_sw(); end
                1: begin rd_vld = 1'b1; rd_id = IW'(5); end
                default: begin
                    mrg_vld = 1'b1; mrg_id = IW'(1); mrg_data = rnd_dw(); mrg_strb = rnd_sw();
                    rel_vld = 1'b1; rel_id = IW'(1);
                end
            endcase
            cycle(); idle();
            chk("illegal_err", err, 1);
            cycle();
        end

        // Reset with a read in flight.
        do_reset();
        alloc_n(4);
        rd_vld = 1'b1; rd_id = IW'(2); rst = 1'b1;
        cycle(); idle();
        chk("rst_rd_vld", rd_data_vld, 0);
        chk("rst2_alloc_rdy", alloc_rdy, 1);
        chk("rst2_alloc_id", alloc_id, 0);
`ifdef VEC_CACHE_DB_STAT_EN
        chk("rst2_occ_max", occ_max, 0);
`endif

        // Changing alloc data while stalled on a full pool.
        alloc_n(N);
        alloc_vld = 1'b1; alloc_data = rnd_dw(); cycle();
        chk("stall_no_err", err, 0);
        alloc_data = ~alloc_data; cycle(); idle();
        chk("stall_chg_err", err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
